// File: rtl/pattern_loader.sv
// Loader in front of the 32x8 pattern buffer: takes a 32-byte pattern on a
// valid/ready byte stream and writes it either by one-hot field writes or through the shift chain.
module pattern_loader #(
  parameter int buffer_width = 8,
  parameter int buffer_size  = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    mode,
  input  logic [buffer_width-1:0] in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [buffer_width-1:0] rd_data,
  output logic                    rd_valid,
  output logic                    busy,
  output logic                    done,
  output logic                    ssel,
  output logic                    sin,
  input  logic                    sout,
  output logic [buffer_size-1:0]  fieldwp,
  output logic [buffer_width-1:0] field_in,
  output logic                    field_write,
  output logic [3:0]              dbg_state
);

  localparam int IDX_W = $clog2(buffer_size);
  localparam int BIT_W = $clog2(buffer_width);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(buffer_size - 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(buffer_width - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PLOAD  = 3'd1,
    SLOAD  = 3'd2,
    SSHIFT = 3'd3,
    DONE   = 3'd4
  } state_e;

  state_e                  state_q, state_d;
  logic                    mode_q, mode_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [BIT_W-1:0]        bit_q, bit_d;
  logic [buffer_width-1:0] shreg_q, shreg_d;
  logic [buffer_width-1:0] rx_q, rx_d;

  logic                    in_ready_q, in_ready_d;
  logic [buffer_width-1:0] rd_data_q, rd_data_d;
  logic                    rd_valid_q, rd_valid_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    ssel_q, ssel_d;
  logic                    sin_q, sin_d;
  logic [buffer_size-1:0]  fieldwp_q, fieldwp_d;
  logic [buffer_width-1:0] field_in_q, field_in_d;
  logic                    field_write_q, field_write_d;

  // Handshake: a byte transfers at a rising edge where in_valid and in_ready are
  // both high; in_ready is registered, so the host sees it a full cycle ahead.
  logic accept;
  assign accept = in_valid && in_ready_q;

  always_comb begin
    state_d       = state_q;
    mode_d        = mode_q;
    idx_d         = idx_q;
    bit_d         = bit_q;
    shreg_d       = shreg_q;
    rx_d          = rx_q;
    rd_data_d     = rd_data_q;
    rd_valid_d    = 1'b0;
    ssel_d        = 1'b0;
    sin_d         = 1'b0;
    fieldwp_d     = '0;
    field_in_d    = '0;
    field_write_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          mode_d  = mode;
          idx_d   = '0;
          state_d = mode ? SLOAD : PLOAD;
        end
      end
      PLOAD: begin
        if (accept) begin
          field_write_d    = 1'b1;
          fieldwp_d[idx_q] = 1'b1;
          field_in_d       = in_data;
          idx_d            = idx_q + IDX_W'(1);
          if (idx_q == LAST_IDX) state_d = DONE;
        end
      end
      SLOAD: begin
        if (accept) begin
          ssel_d  = 1'b1;
          sin_d   = in_data[buffer_width-1];
          shreg_d = {in_data[buffer_width-2:0], 1'b0};
          bit_d   = '0;
          state_d = SSHIFT;
        end
      end
      SSHIFT: begin
        // sout is the chain's pre-shift tail bit, so old data arrives MSB first.
        rx_d  = {rx_q[buffer_width-2:0], sout};
        bit_d = bit_q + BIT_W'(1);
        if (bit_q == LAST_BIT) begin
          rd_data_d  = {rx_q[buffer_width-2:0], sout};
          rd_valid_d = 1'b1;
          idx_d      = idx_q + IDX_W'(1);
          state_d    = (idx_q == LAST_IDX) ? DONE : SLOAD;
        end else begin
          ssel_d  = 1'b1;
          sin_d   = shreg_q[buffer_width-1];
          shreg_d = {shreg_q[buffer_width-2:0], 1'b0};
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d     = (state_d == PLOAD) || (state_d == SLOAD) || (state_d == SSHIFT);
    in_ready_d = (state_d == PLOAD) || (state_d == SLOAD);
    done_d     = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      mode_q        <= 1'b0;
      idx_q         <= '0;
      bit_q         <= '0;
      shreg_q       <= '0;
      rx_q          <= '0;
      in_ready_q    <= 1'b0;
      rd_data_q     <= '0;
      rd_valid_q    <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      ssel_q        <= 1'b0;
      sin_q         <= 1'b0;
      fieldwp_q     <= '0;
      field_in_q    <= '0;
      field_write_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      mode_q        <= mode_d;
      idx_q         <= idx_d;
      bit_q         <= bit_d;
      shreg_q       <= shreg_d;
      rx_q          <= rx_d;
      in_ready_q    <= in_ready_d;
      rd_data_q     <= rd_data_d;
      rd_valid_q    <= rd_valid_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      ssel_q        <= ssel_d;
      sin_q         <= sin_d;
      fieldwp_q     <= fieldwp_d;
      field_in_q    <= field_in_d;
      field_write_q <= field_write_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign rd_data     = rd_data_q;
  assign rd_valid    = rd_valid_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign ssel        = ssel_q;
  assign sin         = sin_q;
  assign fieldwp     = fieldwp_q;
  assign field_in    = field_in_q;
  assign field_write = field_write_q;
  assign dbg_state   = {mode_q, state_q};

endmodule

// File: tb/tb_pattern_loader.sv
// Bench for pattern_loader with a behavioural 32x8 pattern buffer attached to its
// write and shift interface.
module tb_pattern_loader;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        mode;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic        busy;
  logic        done;
  logic        ssel;
  logic        sin;
  logic        sout;
  logic [31:0] fieldwp;
  logic [7:0]  field_in;
  logic        field_write;
  logic [3:0]  dbg_state;

  pattern_loader #(.buffer_width(8), .buffer_size(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .mode       (mode),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .busy       (busy),
    .done       (done),
    .ssel       (ssel),
    .sin        (sin),
    .sout       (sout),
    .fieldwp    (fieldwp),
    .field_in   (field_in),
    .field_write(field_write),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // behavioural pattern buffer
  logic [7:0] mem [32];
  logic       preload_en;
  assign sout = mem[31][7];

  always @(posedge clk) begin
    if (preload_en) begin
      for (int k = 0; k < 32; k++) mem[k] <= 8'(8'hA0 + k);
    end else begin
      if (ssel) begin
        mem[0] <= {mem[0][6:0], sin};
        for (int k = 1; k < 32; k++) mem[k] <= {mem[k][6:0], mem[k-1][7]};
      end
      if (field_write) begin
        for (int k = 0; k < 32; k++) if (fieldwp[k]) mem[k] <= field_in;
      end
    end
  end

  // scoreboard
  int n_cmp = 0;
  int n_err = 0;
  int done_cnt = 0;
  int ssel_cnt = 0;
  logic [39:0] wr_exp_q[$];
  logic [7:0]  rd_exp_q[$];
  logic [0:0]  sin_exp_q[$];
  logic [39:0] w_exp;
  logic [7:0]  r_exp;
  logic [0:0]  s_exp;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // monitor
  always @(negedge clk) begin
    if (rst_n) begin
      check("ssel_wr_excl", 64'(ssel && field_write), 64'd0);
      if (field_write) begin
        if (wr_exp_q.size() == 0) check("wr_unexpected", 64'd1, 64'd0);
        else begin
          w_exp = wr_exp_q.pop_front();
          check("field_wr", 64'({fieldwp, field_in}), 64'(w_exp));
        end
      end else begin
        check("wp_idle", 64'(fieldwp), 64'd0);
      end
      if (ssel) begin
        ssel_cnt++;
        if (sin_exp_q.size() == 0) check("ssel_unexpected", 64'd1, 64'd0);
        else begin
          s_exp = sin_exp_q.pop_front();
          check("sin_bit", 64'(sin), 64'(s_exp));
        end
      end
      if (rd_valid) begin
        if (rd_exp_q.size() == 0) check("rd_unexpected", 64'd1, 64'd0);
        else begin
          r_exp = rd_exp_q.pop_front();
          check("rd_data", 64'(rd_data), 64'(r_exp));
        end
      end
      if (done) begin
        done_cnt++;
        check("busy_at_done", 64'(busy), 64'd0);
        check("in_ready_at_done", 64'(in_ready), 64'd0);
      end
    end
  end

  // driver tasks
  task automatic start_load(input logic m);
    done_cnt = 0;
    ssel_cnt = 0;
    start = 1'b1;
    mode  = m;
    @(posedge clk); #1;
    start = 1'b0;
    mode  = 1'b0;
    check("busy_after_start", 64'(busy), 64'd1);
    check("in_ready_after_start", 64'(in_ready), 64'd1);
  endtask

  task automatic push_byte(input logic [7:0] b);
    int  t  = 0;
    bit  ok = 0;
    in_data  = b;
    in_valid = 1'b1;
    while (!ok && t < 50) begin
      @(negedge clk);
      t++;
      if (in_ready) ok = 1;
    end
    if (!ok) check("accept_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
  endtask

  task automatic wait_done(input string name);
    int t = 0;
    in_valid = 1'b0;
    while (done_cnt == 0 && t < 50) begin
      @(posedge clk);
      t++;
    end
    check({name, "_done_seen"}, 64'(done_cnt != 0), 64'd1);
    repeat (3) @(posedge clk);
    #1;
    check({name, "_done_once"}, 64'(done_cnt), 64'd1);
    check({name, "_idle_busy"}, 64'(busy), 64'd0);
    check({name, "_idle_state"}, 64'(dbg_state[2:0]), 64'd0);
  endtask

  task automatic send_par(input logic [7:0] base, input bit gaps);
    logic [31:0] wp;
    start_load(1'b0);
    for (int i = 0; i < 32; i++) begin
      wp = 32'd1 << i;
      wr_exp_q.push_back({wp, 8'(base + i)});
      push_byte(8'(base + i));
      if (gaps) begin
        in_valid = 1'b0;
        if (i == 10) begin
          start = 1'b1;
          mode  = 1'b1;
        end
        @(posedge clk); #1;
        start = 1'b0;
        mode  = 1'b0;
      end
    end
    wait_done("par");
  endtask

  task automatic send_ser(input logic [7:0] b, input logic [7:0] rd_exp);
    for (int j = 7; j >= 0; j--) sin_exp_q.push_back(b[j]);
    rd_exp_q.push_back(rd_exp);
    push_byte(b);
  endtask

  task automatic check_mem(input string name, input logic [7:0] base);
    for (int k = 0; k < 32; k++) check(name, 64'(mem[k]), 64'(8'(base + k)));
  endtask

  // stimulus
  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    mode       = 1'b0;
    in_data    = 8'h00;
    in_valid   = 1'b0;
    preload_en = 1'b0;
    #3;
    check("rst_ssel", 64'(ssel), 64'd0);
    check("rst_field_write", 64'(field_write), 64'd0);
    check("rst_fieldwp", 64'(fieldwp), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_rd_valid", 64'(rd_valid), 64'd0);
    check("rst_state", 64'(dbg_state), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // parallel, back to back
    send_par(8'h00, 1'b0);
    check_mem("par_mem", 8'h00);

    // parallel with alternate-cycle gaps and an ignored start
    send_par(8'h60, 1'b1);
    check_mem("gap_mem", 8'h60);

    // serial over a preloaded buffer, with an ignored start mid-load
    preload_en = 1'b1;
    @(posedge clk); #1;
    preload_en = 1'b0;
    start_load(1'b1);
    for (int i = 0; i < 32; i++) begin
      send_ser(8'(8'h5F - i), 8'(8'hBF - i));
      if (i == 5) begin
        start = 1'b1;
        mode  = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
      end
    end
    wait_done("ser");
    check("ser_ssel_cycles", 64'(ssel_cnt), 64'd256);
    check_mem("ser_mem", 8'h40);

    // reset in the middle of serial byte 3
    start_load(1'b1);
    for (int i = 0; i < 3; i++) send_ser(8'(8'h11 * (i + 1)), 8'(8'h5F - i));
    send_ser(8'hC3, 8'h5C);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_ssel", 64'(ssel), 64'd0);
    check("arst_field_write", 64'(field_write), 64'd0);
    check("arst_in_ready", 64'(in_ready), 64'd0);
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_rd_valid", 64'(rd_valid), 64'd0);
    sin_exp_q.delete();
    rd_exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("arst_state", 64'(dbg_state), 64'd0);

    // fresh load after reset
    send_par(8'h20, 1'b0);
    check_mem("post_rst_mem", 8'h20);

    check("wr_q_empty", 64'(wr_exp_q.size()), 64'd0);
    check("rd_q_empty", 64'(rd_exp_q.size()), 64'd0);
    check("sin_q_empty", 64'(sin_exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
